// File: rtl/hog_result_bus_fifo.sv
// hog_result_bus_fifo: buffers result words ({meta,payload}) from a streaming
// producer and exposes them to a host through a small word-addressed register bus.
// Ports: clk/rst (async active-high); in_* producer valid/ready push side;
//        addr/bus_enable/r_wbar/byte_enable/write_data -> read_data/ack bus slave;
//        irq is a registered threshold level interrupt.
// Register map (word address): 0 DATA (RO, pops), 1 STATUS (RO), 2 THRESH (RW), 3 CTRL (WO).
module hog_result_bus_fifo #(
  parameter int BUS_WIDTH  = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 16,
  parameter int META_WIDTH = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BUS_WIDTH-META_WIDTH-1:0] in_data,
  input  logic [META_WIDTH-1:0]           in_meta,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ADDR_WIDTH-1:0]           addr,
  input  logic                            bus_enable,
  input  logic                            r_wbar,
  input  logic [BUS_WIDTH/8-1:0]          byte_enable,
  input  logic [BUS_WIDTH-1:0]            write_data,
  output logic [BUS_WIDTH-1:0]            read_data,
  output logic                            ack,
  output logic                            irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [ADDR_WIDTH-1:0] A_DATA   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_THRESH = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(3);
  localparam logic [CW-1:0]         DEPTH_C  = CW'(DEPTH);

  // Storage is not reset; only the pointers/count qualify its contents.
  logic [BUS_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]        count_q, count_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic                 ack_q;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                 irq_q, irq_d;
  logic [CW-1:0]        thresh_q, thresh_d;
  logic                 irq_en_q, irq_en_d;
  logic                 unf_q, unf_d;

  logic accept, rd_acc, wr_acc, empty, full, push, pop, unf_set;
  logic ctrl_wr, thr_wr, flush;
  logic [BUS_WIDTH-1:0] status_w, rdmux;

  // Bits of the write bus that no register decodes.
  logic unused_bits;
  assign unused_bits = ^{write_data, byte_enable};

  always_comb begin
    // A new transaction is only taken when no ack is outstanding.
    accept   = bus_enable && !ack_q;
    rd_acc   = accept && r_wbar;
    wr_acc   = accept && !r_wbar;
    empty    = (count_q == '0);
    full     = (count_q == DEPTH_C);
    in_ready = !full && !rst;
    push     = in_valid && in_ready;
    pop      = rd_acc && (addr == A_DATA) && !empty;
    unf_set  = rd_acc && (addr == A_DATA) && empty;
    ctrl_wr  = wr_acc && (addr == A_CTRL) && byte_enable[0];
    thr_wr   = wr_acc && (addr == A_THRESH) && byte_enable[0] && ((CW <= 8) || byte_enable[1]);
    flush    = ctrl_wr && write_data[1];

    status_w              = '0;
    status_w[CW-1:0]      = count_q;
    status_w[16]          = empty;
    status_w[17]          = full;
    status_w[18]          = unf_q;
    status_w[19]          = irq_q;

    rdmux = '0;
    case (addr)
      A_DATA:   rdmux = empty ? '0 : mem[rd_ptr_q];
      A_STATUS: rdmux = status_w;
      A_THRESH: rdmux[CW-1:0] = thresh_q;
      default:  rdmux = '0;
    endcase

    // Flush wins over a coincident push: the pushed word is dropped.
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end

    rdata_d = rdata_q;
    if (accept) rdata_d = r_wbar ? rdmux : '0;

    thresh_d = thr_wr ? write_data[CW-1:0] : thresh_q;
    irq_en_d = ctrl_wr ? write_data[0] : irq_en_q;

    unf_d = unf_q;
    if (unf_set)                        unf_d = 1'b1;
    else if (ctrl_wr && write_data[2])  unf_d = 1'b0;

    irq_d = irq_en_q && (thresh_q != '0) && (count_q >= thresh_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {in_meta, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      thresh_q <= '0;
      irq_en_q <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_q    <= accept;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      thresh_q <= thresh_d;
      irq_en_q <= irq_en_d;
      unf_q    <= unf_d;
    end
  end

  assign read_data = rdata_q;
  assign ack       = ack_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_hog_result_bus_fifo.sv
module tb_hog_result_bus_fifo;

  localparam int BW = 128;
  localparam int MW = 3;
  localparam int DW = BW - MW;

  localparam int K_PUSH = 0;
  localparam int K_RD   = 1;
  localparam int K_WR   = 2;
  localparam int K_IRQ  = 3;

  localparam logic [15:0] BE_ALL = 16'hFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [MW-1:0] in_meta = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    addr = '0;
  logic          bus_enable = 1'b0;
  logic          r_wbar = 1'b0;
  logic [15:0]   byte_enable = '0;
  logic [BW-1:0] write_data = '0;
  logic [BW-1:0] read_data;
  logic          ack;
  logic          irq;

  int n_checks = 0;
  int n_errors = 0;

  hog_result_bus_fifo dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_meta(in_meta), .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .bus_enable(bus_enable), .r_wbar(r_wbar), .byte_enable(byte_enable),
    .write_data(write_data), .read_data(read_data), .ack(ack), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [4:0]  a;
    logic [127:0] d;
    logic [2:0]  m;
    logic [15:0] be;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [127:0] mk(input logic [2:0] m, input int p);
    logic [DW-1:0] pl;
    pl = DW'(p);
    return {m, pl};
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int k, input logic [4:0] a, input logic [127:0] d,
                     input logic [2:0] m, input logic [15:0] be, input logic [127:0] e);
    vec_t v;
    v.kind = k; v.a = a; v.d = d; v.m = m; v.be = be; v.exp = e;
    tbl.push_back(v);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that ends the ack cycle.
  task automatic bus_xfer(input logic rw, input logic [4:0] a, input logic [127:0] wd,
                          input logic [15:0] be, output logic [127:0] rd, output logic rdy_at_ack);
    int waited;
    logic got;
    bus_enable = 1'b1; r_wbar = rw; addr = a; write_data = wd; byte_enable = be;
    waited = 0; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      waited++;
      if (ack) got = 1'b1;
    end
    bus_enable = 1'b0;
    check("ack_latency", 128'(waited), 128'd1);
    rd = read_data;
    rdy_at_ack = in_ready;
    if (!rw) check("wr_read_data_zero", read_data, '0);
    @(posedge clk); #1;
    check("ack_one_cycle", 128'(ack), 128'd0);
  endtask

  task automatic push_word(input logic [2:0] m, input int p);
    logic done;
    in_meta = m; in_data = DW'(p); in_valid = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("push_accepted", 128'(done), 128'd1);
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] a, input logic [127:0] e);
    logic [127:0] rd;
    logic r;
    bus_xfer(1'b1, a, '0, BE_ALL, rd, r);
    check(nm, rd, e);
  endtask

  task automatic wr(input logic [4:0] a, input logic [127:0] d);
    logic [127:0] rd;
    logic r;
    bus_xfer(1'b0, a, d, BE_ALL, rd, r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] rd;
    logic         rdy;
    int           k;

    // Vectors: push/read ordering, underflow, THRESH/CTRL, irq, unmapped space.
    add(K_PUSH, 0, 1, 3'b101, 0, 0);
    add(K_PUSH, 0, 2, 3'b101, 0, 0);
    add(K_PUSH, 0, 3, 3'b101, 0, 0);
    add(K_RD,   1, 0, 0, BE_ALL, 128'h3);
    add(K_RD,   0, 0, 0, BE_ALL, mk(3'b101, 1));
    add(K_RD,   0, 0, 0, BE_ALL, mk(3'b101, 2));
    add(K_RD,   0, 0, 0, BE_ALL, mk(3'b101, 3));
    add(K_RD,   1, 0, 0, BE_ALL, 128'h10000);
    add(K_RD,   0, 0, 0, BE_ALL, 128'h0);
    add(K_RD,   1, 0, 0, BE_ALL, 128'h50000);
    add(K_WR,   3, 4, 0, BE_ALL, 0);
    add(K_RD,   1, 0, 0, BE_ALL, 128'h10000);
    add(K_WR,   2, 7, 0, 16'h0, 0);
    add(K_RD,   2, 0, 0, BE_ALL, 128'h0);
    add(K_WR,   2, 4, 0, BE_ALL, 0);
    add(K_RD,   2, 0, 0, BE_ALL, 128'h4);
    add(K_WR,   3, 1, 0, BE_ALL, 0);
    add(K_PUSH, 0, 10, 3'b001, 0, 0);
    add(K_PUSH, 0, 11, 3'b001, 0, 0);
    add(K_PUSH, 0, 12, 3'b001, 0, 0);
    add(K_IRQ,  0, 0, 0, 0, 128'd0);
    add(K_PUSH, 0, 13, 3'b001, 0, 0);
    add(K_IRQ,  0, 0, 0, 0, 128'd1);
    add(K_RD,   1, 0, 0, BE_ALL, 128'h80004);
    add(K_RD,   0, 0, 0, BE_ALL, mk(3'b001, 10));
    add(K_IRQ,  0, 0, 0, 0, 128'd0);
    add(K_RD,   1, 0, 0, BE_ALL, 128'h3);
    add(K_WR,   2, 0, 0, BE_ALL, 0);
    add(K_PUSH, 0, 14, 3'b001, 0, 0);
    add(K_PUSH, 0, 15, 3'b001, 0, 0);
    add(K_IRQ,  0, 0, 0, 0, 128'd0);
    add(K_RD,   7, 0, 0, BE_ALL, 128'h0);
    add(K_WR,   0, 128'hFF, 0, BE_ALL, 0);
    add(K_WR,   1, 128'hFF, 0, BE_ALL, 0);
    add(K_RD,   1, 0, 0, BE_ALL, 128'h5);
    add(K_RD,   3, 0, 0, BE_ALL, 128'h0);
    add(K_WR,   3, 2, 0, BE_ALL, 0);
    add(K_RD,   1, 0, 0, BE_ALL, 128'h10000);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", 128'(ack), 128'd0);
    check("rst_read_data", read_data, '0);
    check("rst_irq", 128'(irq), 128'd0);
    check("rst_in_ready", 128'(in_ready), 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_PUSH: push_word(tbl[i].m, int'(tbl[i].d[31:0]));
        K_RD: begin
          bus_xfer(1'b1, tbl[i].a, '0, tbl[i].be, rd, rdy);
          check($sformatf("vec%0d_read", i), rd, tbl[i].exp);
        end
        K_WR: bus_xfer(1'b0, tbl[i].a, tbl[i].d, tbl[i].be, rd, rdy);
        default: begin
          repeat (2) @(posedge clk);
          #1;
          check($sformatf("vec%0d_irq", i), 128'(irq), tbl[i].exp);
        end
      endcase
    end

    // Fill with in_valid held until backpressure.
    in_meta = 3'd2; k = 0; in_data = DW'(k); in_valid = 1'b1;
    for (int c = 0; c < 40 && in_ready; c++) begin
      @(posedge clk); #1;
      k++;
      in_data = DW'(k);
    end
    in_valid = 1'b0;
    check("fill_count", 128'(k), 128'd16);
    check("full_in_ready", 128'(in_ready), 128'd0);
    rd_chk("full_status", 1, 128'h20010);
    bus_xfer(1'b1, 0, '0, BE_ALL, rd, rdy);
    check("full_pop_data", rd, mk(3'd2, 0));
    check("in_ready_after_pop", 128'(rdy), 128'd1);
    for (int j = 1; j < 16; j++) rd_chk($sformatf("drain%0d", j), 0, mk(3'd2, j));

    // Pointer wrap: 40 more words through the 16-deep buffer.
    for (int g = 0; g < 4; g++) begin
      for (int j = 0; j < 10; j++) push_word(3'd3, 200 + g * 10 + j);
      for (int j = 0; j < 10; j++) rd_chk($sformatf("wrap%0d", g * 10 + j), 0, mk(3'd3, 200 + g * 10 + j));
    end
    rd_chk("wrap_status", 1, 128'h10000);

    // Flush with a coincident push: the pushed word must be lost.
    for (int j = 0; j < 5; j++) push_word(3'd4, 50 + j);
    bus_enable = 1'b1; r_wbar = 1'b0; addr = 5'd3; write_data = 128'h2; byte_enable = BE_ALL;
    in_valid = 1'b1; in_meta = 3'd4; in_data = DW'(99);
    @(posedge clk); #1;
    bus_enable = 1'b0; in_valid = 1'b0;
    check("flush_ack", 128'(ack), 128'd1);
    @(posedge clk); #1;
    rd_chk("flush_status", 1, 128'h10000);
    rd_chk("flush_data_lost", 0, 128'h0);
    wr(3, 128'h4);

    // Reset in the middle of a read with 5 words stored.
    wr(2, 128'h3);
    wr(3, 128'h1);
    for (int j = 0; j < 5; j++) push_word(3'd5, 70 + j);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_irq", 128'(irq), 128'd1);
    bus_enable = 1'b1; r_wbar = 1'b1; addr = 5'd0; byte_enable = BE_ALL;
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    bus_enable = 1'b0;
    check("mid_rst_ack", 128'(ack), 128'd0);
    check("mid_rst_read_data", read_data, '0);
    check("mid_rst_irq", 128'(irq), 128'd0);
    check("mid_rst_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    check("mid_rst_ack2", 128'(ack), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("post_rst_status", 1, 128'h10000);
    rd_chk("post_rst_thresh", 2, 128'h0);
    rd_chk("post_rst_data", 0, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
